// File: rtl/instruction_sequencer.sv
// instruction_sequencer: drives the processor DIN/Run/Done handshake from a small program memory
//   Clock/Resetn          : rising-edge clock, synchronous active-low reset
//   start                 : level input; a rising edge while idle launches the program
//   prog_we/addr/data     : program memory write port, honoured only while idle
//   prog_len              : number of program words, sampled at launch
//   Done                  : processor instruction-complete flag
//   DIN/Run               : registered instruction word and one-cycle issue strobe
//   busy/finished/error   : sequencing, halted, sticky fault status
//   pc                    : index of the current program word
module instruction_sequencer #(
    parameter int         ADDR_WIDTH = 5,
    parameter int         DATA_WIDTH = 16,
    parameter logic [2:0] MVI_OPCODE = 3'b001,
    parameter int         TIMEOUT    = 64
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  start,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    input  logic [ADDR_WIDTH:0]   prog_len,
    input  logic                  Done,
    output logic [DATA_WIDTH-1:0] DIN,
    output logic                  Run,
    output logic                  busy,
    output logic                  finished,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] pc
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = $clog2(TIMEOUT);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_IMM, S_WAIT, S_HALT, S_ERR} state_t;
    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_din, w_din;
    logic                  r_run, w_run, r_err, w_err, r_start_q;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc;
    logic [ADDR_WIDTH:0]   r_len, w_len, w_pc_inc;
    logic [CW-1:0]         r_cnt, w_cnt;
    logic                  w_launch, w_is_mvi;
    logic [DATA_WIDTH-1:0] w_word_nx;
    // pc+1 is one bit wider than pc so the last-word test never wraps to address 0
    assign w_pc_inc  = {1'b0, r_pc} + (ADDR_WIDTH + 1)'(1);
    assign w_word_nx = r_mem[w_pc_inc[ADDR_WIDTH-1:0]];
    assign w_launch  = start && !r_start_q;
    assign w_is_mvi  = r_din[8:6] == MVI_OPCODE;
    always_comb begin
        w_next = r_state;
        w_din  = r_din;
        w_run  = 1'b0;
        w_pc   = r_pc;
        w_len  = r_len;
        w_cnt  = r_cnt;
        w_err  = r_err;
        case (r_state)
            S_IDLE: if (w_launch) begin
                w_err = 1'b0;
                if (prog_len == '0) w_next = S_HALT;
                else begin
                    w_len  = prog_len;
                    w_pc   = '0;
                    w_din  = r_mem[0];
                    w_run  = 1'b1;
                    w_next = S_ISSUE;
                end
            end
            // DIN already holds mem[pc] here, so the opcode is decoded from the register
            S_ISSUE: begin
                w_cnt = '0;
                if (!w_is_mvi) w_next = S_WAIT;
                else if (w_pc_inc < r_len) begin
                    w_next = S_IMM;
                    w_pc   = w_pc_inc[ADDR_WIDTH-1:0];
                    w_din  = w_word_nx;
                end else begin
                    w_next = S_ERR;
                    w_err  = 1'b1;
                end
            end
            // Done is checked before the timeout so a late Done still completes
            S_IMM, S_WAIT: if (Done) begin
                if (w_pc_inc == r_len) w_next = S_HALT;
                else begin
                    w_pc   = w_pc_inc[ADDR_WIDTH-1:0];
                    w_din  = w_word_nx;
                    w_run  = 1'b1;
                    w_next = S_ISSUE;
                end
            end else if (r_cnt == CW'(TIMEOUT - 2)) begin
                w_next = S_ERR;
                w_err  = 1'b1;
            end else begin
                w_cnt  = r_cnt + CW'(1);
                w_next = S_WAIT;
            end
            S_HALT, S_ERR: w_next = start ? r_state : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state   <= S_IDLE;
            r_din     <= '0;
            r_run     <= 1'b0;
            r_pc      <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_din     <= w_din;
            r_run     <= w_run;
            r_pc      <= w_pc;
            r_len     <= w_len;
            r_cnt     <= w_cnt;
            r_err     <= w_err;
            r_start_q <= start;
        end
    end
    always_ff @(posedge Clock) begin
        if (prog_we && r_state == S_IDLE) r_mem[prog_addr] <= prog_data;
    end
    assign DIN      = r_din;
    assign Run      = r_run;
    assign pc       = r_pc;
    assign error    = r_err;
    assign busy     = r_state == S_ISSUE || r_state == S_IMM || r_state == S_WAIT;
    assign finished = r_state == S_HALT;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: scoreboard bench for instruction_sequencer against a program-walk model
module tb_instruction_sequencer;
    localparam int K_RUN = 0, K_IMM = 1, K_FIN = 2, K_ERR = 3;
    localparam int TMO = 64;
    typedef struct {int kind; logic [15:0] val;} exp_t;
    logic        Clock, Resetn, start, prog_we, Done;
    logic [4:0]  prog_addr, pc;
    logic [15:0] prog_data, DIN;
    logic [5:0]  prog_len;
    logic        Run, busy, finished, error;
    exp_t        q[$];
    logic [15:0] mem_m [32];
    int          errors = 0, checks = 0, model_pc = 0, cyc = 0, last_run = 0;
    logic        auto_done = 1'b1;
    int          done_delay = 2;
    logic        imm_arm = 1'b0, prev_run = 1'b0, prev_fin = 1'b0, prev_err = 1'b0;
    logic [15:0] imm_val = '0;

    instruction_sequencer dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_len(prog_len), .Done(Done),
        .DIN(DIN), .Run(Run), .busy(busy), .finished(finished), .error(error), .pc(pc)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push(input int kind, input logic [15:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endfunction

    // Walks the program as the processor would see it; nodone means Done never arrives
    function automatic void model(input int len, input bit nodone);
        int i = 0;
        if (len == 0) begin
            push(K_FIN, 16'(model_pc));
            return;
        end
        while (i < len) begin
            push(K_RUN, mem_m[i]);
            model_pc = i;
            if (mem_m[i][8:6] == 3'b001) begin
                if (i + 1 >= len) begin
                    push(K_ERR, 16'd1);
                    return;
                end
                push(K_IMM, mem_m[i+1]);
                model_pc = i + 1;
                i += 2;
            end else i += 1;
            if (nodone) begin
                push(K_ERR, 16'(TMO));
                return;
            end
        end
        push(K_FIN, 16'(model_pc));
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] w = 16'($urandom);
        int o = $urandom_range(0, 6);
        if (o >= 1) o++;
        w[8:6] = ($urandom_range(0, 3) == 0) ? 3'b001 : 3'(o);
        return w;
    endfunction

    task automatic load_word(input int a, input logic [15:0] d);
        @(negedge Clock);
        prog_we   = 1'b1;
        prog_addr = a[4:0];
        prog_data = d;
        mem_m[a]  = d;
        @(negedge Clock);
        prog_we = 1'b0;
    endtask

    task automatic launch(input int len);
        @(negedge Clock);
        prog_len = 6'(len);
        start    = 1'b1;
        @(negedge Clock);
    endtask

    task automatic wait_end();
        int n = 0;
        while (!finished && !error && n < 5000) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL end_wait: got no finished/error expected one within 5000 cycles");
        end
        start = 1'b0;
        repeat (8) @(negedge Clock);
    endtask

    // Done responder: answers each Run after a fixed or random delay when enabled
    initial begin
        Done = 1'b0;
        forever begin
            if (Run && auto_done) begin
                repeat (done_delay > 0 ? done_delay : $urandom_range(1, 4)) @(negedge Clock);
                Done = 1'b1;
                @(negedge Clock);
                Done = 1'b0;
            end else @(negedge Clock);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a Run pulse or a status edge
    always @(negedge Clock) begin
        exp_t e;
        cyc++;
        if (imm_arm) begin
            chk("imm_din", DIN, imm_val);
            chk("imm_run", Run, 0);
            imm_arm = 1'b0;
        end
        if (Run) begin
            chk("run_gap", prev_run, 0);
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL run_unexpected: got Run with DIN=%0h expected no Run", DIN);
            end else begin
                e = q.pop_front();
                chk("run_kind", e.kind, K_RUN);
                chk("run_din", DIN, e.val);
                if (q.size() > 0 && q[0].kind == K_IMM) begin
                    e = q.pop_front();
                    imm_arm = 1'b1;
                    imm_val = e.val;
                end
            end
            last_run = cyc;
        end
        if (finished && !prev_fin) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL fin_unexpected: got finished=1 expected 0");
            end else begin
                e = q.pop_front();
                chk("fin_kind", e.kind, K_FIN);
                chk("fin_pc", pc, e.val);
            end
        end
        if (error && !prev_err) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL err_unexpected: got error=1 expected 0");
            end else begin
                e = q.pop_front();
                chk("err_kind", e.kind, K_ERR);
                chk("err_delay", cyc - last_run, e.val);
            end
        end
        prev_run = Run;
        prev_fin = finished;
        prev_err = error;
    end

    initial begin
        int len;
        Resetn = 1'b0; start = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_data = '0; prog_len = '0;
        repeat (3) @(negedge Clock);
        chk("rst_din", DIN, 0);
        chk("rst_run", Run, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fin", finished, 0);
        chk("rst_err", error, 0);
        chk("rst_pc", pc, 0);
        Resetn = 1'b1;
        load_word(0, 16'h0008);
        load_word(1, 16'h0050);
        model(2, 0); launch(2); wait_end();
        load_word(0, 16'h0040);
        load_word(1, 16'h0005);
        model(2, 0); launch(2); wait_end();
        model(1, 0); launch(1); wait_end();
        chk("mvi_err_sticky", error, 1);
        chk("mvi_err_fin", finished, 0);
        load_word(0, 16'h0008);
        auto_done = 1'b0;
        model(1, 1); launch(1); wait_end();
        chk("tmo_err_sticky", error, 1);
        chk("tmo_err_busy", busy, 0);
        auto_done = 1'b1;
        done_delay = 6;
        model(1, 0); launch(1);
        chk("err_clear", error, 0);
        @(negedge Clock);
        prog_we = 1'b1; prog_addr = '0; prog_data = 16'hFFFF;
        @(negedge Clock);
        prog_we = 1'b0;
        wait_end();
        model(1, 0); launch(1); wait_end();
        model(0, 0); launch(0);
        chk("len0_fin", finished, 1);
        chk("len0_run", Run, 0);
        wait_end();
        auto_done = 1'b0;
        push(K_RUN, mem_m[0]);
        launch(1);
        @(negedge Clock);
        chk("wait_busy", busy, 1);
        Resetn = 1'b0;
        start  = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        model_pc = 0;
        chk("rst2_run", Run, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_pc", pc, 0);
        chk("rst2_din", DIN, 0);
        chk("rst2_q_empty", q.size(), 0);
        repeat (4) @(negedge Clock);
        auto_done = 1'b1;
        done_delay = 0;
        for (int it = 0; it < 20; it++) begin
            len = (it == 0) ? 32 : $urandom_range(1, 32);
            for (int a = 0; a < len; a++) load_word(a, rand_word());
            model(len, 0);
            launch(len);
            wait_end();
        end
        chk("final_q_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
